// File: rtl/host_if_bridge_if.sv
// ---------------------------------------------------------------------------
// host_if_bridge_if
// Bundles the host/engine handshake and data signals of host_if_bridge.
//   Host ingress : I_Host_Valid, O_Host_Ready, I_Host_Data, I_Host_Last
//   Engine issue : O_Req_IF, O_Data_IF, I_Eng_Stall, I_Eng_Done
//   Engine output: I_Req_IF, I_Data_IF
//   Host egress  : O_Host_Valid, I_Host_Ready, O_Host_Data
// The slave modport is the bridge's view. The master modport is the view of
// the surrounding host/engine, which drives the I_* signals.
// ---------------------------------------------------------------------------
interface host_if_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  I_Host_Valid;
    logic                  O_Host_Ready;
    logic [DATA_WIDTH-1:0] I_Host_Data;
    logic                  I_Host_Last;
    logic                  O_Req_IF;
    logic [DATA_WIDTH-1:0] O_Data_IF;
    logic                  I_Eng_Stall;
    logic                  I_Eng_Done;
    logic                  I_Req_IF;
    logic [DATA_WIDTH-1:0] I_Data_IF;
    logic                  O_Host_Valid;
    logic                  I_Host_Ready;
    logic [DATA_WIDTH-1:0] O_Host_Data;

    modport slave (
        input  I_Host_Valid, I_Host_Data, I_Host_Last,
        input  I_Eng_Stall, I_Eng_Done, I_Req_IF, I_Data_IF, I_Host_Ready,
        output O_Host_Ready, O_Req_IF, O_Data_IF, O_Host_Valid, O_Host_Data
    );

    modport master (
        output I_Host_Valid, I_Host_Data, I_Host_Last,
        output I_Eng_Stall, I_Eng_Done, I_Req_IF, I_Data_IF, I_Host_Ready,
        input  O_Host_Ready, O_Req_IF, O_Data_IF, O_Host_Valid, O_Host_Data
    );
endinterface

// File: rtl/host_if_bridge.sv
// ---------------------------------------------------------------------------
// host_if_bridge
// Buffers a host valid/ready word stream in an ingress FIFO and issues it to
// the engine as single-cycle request pulses, one program (terminated by a
// last flag) at a time. Engine output pulses are captured in a
// first-word-fall-through egress FIFO that the host drains with valid/ready.
// After the last word of a program the bridge waits for I_Eng_Done and
// aborts after TIMEOUT cycles.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : host_if_bridge_if.slave (host and engine handshakes)
//   O_Busy       : FSM not in IDLE
//   O_Fwd_Cnt    : words forwarded in the current program (saturating)
//   O_Overflow   : sticky, an egress word was dropped
//   O_Timeout    : sticky, the wait for engine completion expired
// ---------------------------------------------------------------------------
module host_if_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_DEPTH   = 8,
    parameter int OUT_DEPTH  = 8,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    host_if_bridge_if.slave       bus,
    output logic                  O_Busy,
    output logic [CNT_WIDTH-1:0]  O_Fwd_Cnt,
    output logic                  O_Overflow,
    output logic                  O_Timeout
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IN_AW:0]    IN_FULL  = (IN_AW + 1)'(IN_DEPTH);
    localparam logic [OUT_AW:0]   OUT_FULL = (OUT_AW + 1)'(OUT_DEPTH);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state, state_n;

    // ---------------- ingress FIFO: {last, data} ----------------
    logic [DATA_WIDTH:0]   in_mem [IN_DEPTH];
    logic [IN_AW-1:0]      in_wr_ptr, in_rd_ptr;
    logic [IN_AW:0]        in_cnt;
    logic                  in_full, in_empty;
    logic                  in_push, in_pop;
    logic                  ready_en;
    logic [DATA_WIDTH-1:0] in_head_data;
    logic                  in_head_last;

    assign in_full      = (in_cnt == IN_FULL);
    assign in_empty     = (in_cnt == '0);
    assign in_head_data = in_mem[in_rd_ptr][DATA_WIDTH-1:0];
    assign in_head_last = in_mem[in_rd_ptr][DATA_WIDTH];

    // ready_en keeps O_Host_Ready low while reset is asserted and raises it
    // one edge after release.
    assign bus.O_Host_Ready = ready_en & ~in_full;
    assign in_push          = bus.I_Host_Valid & bus.O_Host_Ready;

    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= {bus.I_Host_Last, bus.I_Host_Data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_cnt    <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
            if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_inc, tmo_set, fwd_clr;
    logic             req_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        in_pop  = 1'b0;
        fwd_clr = 1'b0;
        tmo_inc = 1'b0;
        tmo_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!in_empty) begin
                    state_n = ST_FWD;
                    fwd_clr = 1'b1;
                end
            end
            ST_FWD: begin
                if (!in_empty && !bus.I_Eng_Stall) begin
                    in_pop = 1'b1;
                    if (in_head_last) state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Done takes priority over a coincident expiry.
                if (bus.I_Eng_Done) begin
                    state_n = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ST_IDLE;
                    tmo_set = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q      <= 1'b0;
            data_q     <= '0;
            O_Fwd_Cnt  <= '0;
            tmo_cnt    <= '0;
            O_Timeout  <= 1'b0;
        end else begin
            req_q <= in_pop;
            if (in_pop) data_q <= in_head_data;

            if (fwd_clr)                         O_Fwd_Cnt <= '0;
            else if (in_pop && O_Fwd_Cnt != '1)  O_Fwd_Cnt <= O_Fwd_Cnt + 1'b1;

            // Counter sits at zero outside WAIT_DONE, so it starts at 0 on entry.
            if (state != ST_WAIT) tmo_cnt <= '0;
            else if (tmo_inc)     tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_set) O_Timeout <= 1'b1;
        end
    end

    assign bus.O_Req_IF  = req_q;
    assign bus.O_Data_IF = data_q;
    assign O_Busy        = (state != ST_IDLE);

    // ---------------- egress FIFO (first-word-fall-through) ----------------
    logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]     out_wr_ptr, out_rd_ptr;
    logic [OUT_AW:0]       out_cnt;
    logic                  out_full, out_empty;
    logic                  out_push, out_pop;

    assign out_full  = (out_cnt == OUT_FULL);
    assign out_empty = (out_cnt == '0);
    assign out_pop   = ~out_empty & bus.I_Host_Ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign out_push  = bus.I_Req_IF & (~out_full | out_pop);

    assign bus.O_Host_Valid = ~out_empty;
    assign bus.O_Host_Data  = out_empty ? '0 : out_mem[out_rd_ptr];

    always_ff @(posedge clock) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= bus.I_Data_IF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_cnt    <= '0;
            O_Overflow <= 1'b0;
        end else begin
            if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
            if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (bus.I_Req_IF && !out_push) O_Overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_host_if_bridge.sv
// ---------------------------------------------------------------------------
// tb_host_if_bridge
// Directed bench for host_if_bridge (TIMEOUT=16): a per-cycle vector table
// for a 3-word program, plus hand-written sequences for reset, stall/full
// ingress, timeout, done-vs-expiry, egress overflow and full push/pop.
// ---------------------------------------------------------------------------
module tb_host_if_bridge;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          O_Busy;
    logic [CW-1:0] O_Fwd_Cnt;
    logic          O_Overflow;
    logic          O_Timeout;

    int total = 0;
    int bad   = 0;

    host_if_bridge_if #(.DATA_WIDTH(DW)) bus ();

    host_if_bridge #(
        .DATA_WIDTH(DW),
        .IN_DEPTH  (8),
        .OUT_DEPTH (8),
        .TIMEOUT   (16),
        .CNT_WIDTH (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .O_Busy    (O_Busy),
        .O_Fwd_Cnt (O_Fwd_Cnt),
        .O_Overflow(O_Overflow),
        .O_Timeout (O_Timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          hv;
        logic [DW-1:0] hd;
        logic          hl;
        logic          st;
        logic          dn;
        logic          e_req;
        logic [DW-1:0] e_data;
        logic          e_busy;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one active edge and settle; all driving and checking happens here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.I_Host_Valid = 1'b0;
        bus.I_Host_Data  = '0;
        bus.I_Host_Last  = 1'b0;
        bus.I_Eng_Stall  = 1'b0;
        bus.I_Eng_Done   = 1'b0;
        bus.I_Req_IF     = 1'b0;
        bus.I_Data_IF    = '0;
        bus.I_Host_Ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    // Push one 1-word program; returns just after the edge that enters WAIT_DONE.
    task automatic one_word_prog(input logic [DW-1:0] d);
        bus.I_Host_Valid = 1'b1;
        bus.I_Host_Data  = d;
        bus.I_Host_Last  = 1'b1;
        tick();
        bus.I_Host_Valid = 1'b0;
        bus.I_Host_Last  = 1'b0;
        tick();
        tick();
        check("one_word_req", bus.O_Req_IF, 1);
        check("one_word_data", bus.O_Data_IF, d);
    endtask

    initial begin
        logic [DW-1:0] exp_q [$];

        clear_inputs();
        #12;
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("rst_ready", bus.O_Host_Ready, 1);
        check("rst_busy", O_Busy, 0);
        check("rst_cnt", O_Fwd_Cnt, 0);
        check("rst_hvalid", bus.O_Host_Valid, 0);

        // 3-word program, cycle by cycle
        //          hv  hd     hl  st  dn  req  data   busy cnt rdy
        tbl[0] = '{1, 'h11, 0, 0, 0,  0, 'h00, 0, 0, 1};
        tbl[1] = '{1, 'h22, 0, 0, 0,  0, 'h00, 1, 0, 1};
        tbl[2] = '{1, 'h33, 1, 0, 0,  1, 'h11, 1, 1, 1};
        tbl[3] = '{0, 'h00, 0, 0, 0,  1, 'h22, 1, 2, 1};
        tbl[4] = '{0, 'h00, 0, 0, 0,  1, 'h33, 1, 3, 1};
        tbl[5] = '{0, 'h00, 0, 0, 0,  0, 'h33, 1, 3, 1};
        tbl[6] = '{0, 'h00, 0, 0, 1,  0, 'h33, 0, 3, 1};
        tbl[7] = '{0, 'h00, 0, 0, 0,  0, 'h33, 0, 3, 1};
        for (int i = 0; i < 8; i++) begin
            bus.I_Host_Valid = tbl[i].hv;
            bus.I_Host_Data  = tbl[i].hd;
            bus.I_Host_Last  = tbl[i].hl;
            bus.I_Eng_Stall  = tbl[i].st;
            bus.I_Eng_Done   = tbl[i].dn;
            tick();
            check($sformatf("vec%0d_req", i), bus.O_Req_IF, tbl[i].e_req);
            check($sformatf("vec%0d_data", i), bus.O_Data_IF, tbl[i].e_data);
            check($sformatf("vec%0d_busy", i), O_Busy, tbl[i].e_busy);
            check($sformatf("vec%0d_cnt", i), O_Fwd_Cnt, tbl[i].e_cnt);
            check($sformatf("vec%0d_rdy", i), bus.O_Host_Ready, tbl[i].e_rdy);
        end
        clear_inputs();

        // Asynchronous reset mid-clock: outputs clear before the next edge
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_data", bus.O_Data_IF, 0);
        check("async_cnt", O_Fwd_Cnt, 0);
        check("async_ready", bus.O_Host_Ready, 0);
        check("async_busy", O_Busy, 0);
        check("async_hdata", bus.O_Host_Data, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("post_rst_ready", bus.O_Host_Ready, 1);

        // Stall with ingress filling up
        bus.I_Eng_Stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.I_Host_Valid = 1'b1;
            bus.I_Host_Data  = 32'hA0 + DW'(i);
            bus.I_Host_Last  = (i == 7);
            tick();
        end
        check("full_ready", bus.O_Host_Ready, 0);
        check("stall_req", bus.O_Req_IF, 0);
        bus.I_Host_Valid = 1'b0;
        bus.I_Host_Last  = 1'b0;
        bus.I_Eng_Stall  = 1'b0;
        tick();
        check("unstall_ready", bus.O_Host_Ready, 1);
        check("unstall_req0", bus.O_Req_IF, 1);
        check("unstall_data0", bus.O_Data_IF, 32'hA0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("unstall_req%0d", i), bus.O_Req_IF, 1);
            check($sformatf("unstall_data%0d", i), bus.O_Data_IF, 32'hA0 + DW'(i));
        end
        check("unstall_cnt", O_Fwd_Cnt, 8);
        bus.I_Eng_Done = 1'b1;
        tick();
        bus.I_Eng_Done = 1'b0;
        check("unstall_done_busy", O_Busy, 0);

        // Done coinciding with expiry: Done wins
        do_reset();
        one_word_prog(32'h55);
        for (int i = 0; i < 15; i++) tick();
        check("dve_busy_pre", O_Busy, 1);
        check("dve_tmo_pre", O_Timeout, 0);
        bus.I_Eng_Done = 1'b1;
        tick();
        bus.I_Eng_Done = 1'b0;
        check("dve_busy", O_Busy, 0);
        check("dve_tmo", O_Timeout, 0);

        // Timeout with no Done: sets exactly 16 edges after entering WAIT_DONE
        do_reset();
        one_word_prog(32'h66);
        for (int i = 0; i < 15; i++) tick();
        check("tmo_pre", O_Timeout, 0);
        check("tmo_busy_pre", O_Busy, 1);
        tick();
        check("tmo_set", O_Timeout, 1);
        check("tmo_busy", O_Busy, 0);
        tick();
        check("tmo_sticky", O_Timeout, 1);

        // Egress overflow
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus.I_Req_IF  = 1'b1;
            bus.I_Data_IF = DW'(i);
            tick();
            if (i == 8) check("ovf_pre", O_Overflow, 0);
        end
        bus.I_Req_IF = 1'b0;
        check("ovf_set", O_Overflow, 1);
        bus.I_Host_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_valid%0d", i), bus.O_Host_Valid, 1);
            check($sformatf("ovf_data%0d", i), bus.O_Host_Data, DW'(i));
            tick();
        end
        check("ovf_empty", bus.O_Host_Valid, 0);
        bus.I_Host_Ready = 1'b0;

        // Full egress with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.I_Req_IF  = 1'b1;
            bus.I_Data_IF = DW'(i);
            tick();
        end
        bus.I_Data_IF    = 32'hAA;
        bus.I_Host_Ready = 1'b1;
        tick();
        bus.I_Req_IF = 1'b0;
        check("pp_ovf", O_Overflow, 0);
        for (int i = 2; i <= 8; i++) exp_q.push_back(DW'(i));
        exp_q.push_back(32'hAA);
        foreach (exp_q[i]) begin
            check($sformatf("pp_valid%0d", i), bus.O_Host_Valid, 1);
            check($sformatf("pp_data%0d", i), bus.O_Host_Data, exp_q[i]);
            tick();
        end
        check("pp_empty", bus.O_Host_Valid, 0);
        check("pp_ovf_end", O_Overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/host_if_bridge.md
Name: host_if_bridge

Overview:
Host-side bridge directly upstream and downstream of the engine's external interface (I_Req_IF/I_Data_IF in, O_Req_IF/O_Data_IF out). It buffers a host valid/ready word stream and issues it to the engine as single-cycle request pulses, one program at a time, delimited by a last flag. It captures engine output pulses into an egress FIFO that the host drains through valid/ready. It tracks program completion and timeout.

Parameters:
DATA_WIDTH, 32, width of one interface word (matches mpu_if_t payload)
IN_DEPTH, 8, ingress FIFO entries (power of 2, >=2)
OUT_DEPTH, 8, egress FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in WAIT_DONE before abort
CNT_WIDTH, 16, width of forwarded-word counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
I_Host_Valid  in  1  host ingress word valid
O_Host_Ready  out  1  bridge can accept ingress word
I_Host_Data  in  DATA_WIDTH  host ingress word
I_Host_Last  in  1  word is last of program
O_Req_IF  out  1  request pulse to engine
O_Data_IF  out  DATA_WIDTH  word to engine
I_Eng_Stall  in  1  engine cannot accept a word this cycle
I_Eng_Done  in  1  engine completion pulse (from status decode)
I_Req_IF  in  1  engine output word valid (no backpressure)
I_Data_IF  in  DATA_WIDTH  engine output word
O_Host_Valid  out  1  egress word available
I_Host_Ready  in  1  host accepts egress word
O_Host_Data  out  DATA_WIDTH  egress word
O_Busy  out  1  FSM not in IDLE
O_Fwd_Cnt  out  CNT_WIDTH  words forwarded in current program
O_Overflow  out  1  sticky: egress word dropped
O_Timeout  out  1  sticky: WAIT_DONE expired

Behaviour:
- Reset is asynchronous and active-high, on `reset`, in the `clock` domain. While it is asserted, all FIFOs are emptied, the FSM goes to IDLE, and every output is 0 (O_Host_Ready becomes 1 in the first cycle after release). Reset mid-program discards all buffered words, with no partial completion.
- Ingress FIFO stores {last, data}.
  - O_Host_Ready = !in_full, combinational from the count.
  - Push when I_Host_Valid & O_Host_Ready.
- FSM states: IDLE, FWD, WAIT_DONE.
- IDLE:
  - If the ingress FIFO is non-empty, go to FWD and clear O_Fwd_Cnt.
  - A leftover I_Eng_Done pulse is ignored.
- FWD issue rule: each cycle, if the ingress FIFO is non-empty and !I_Eng_Stall, pop the head. Next cycle O_Req_IF=1 and O_Data_IF=head (registered, 1-cycle latency).
- FWD otherwise: O_Req_IF=0 and O_Data_IF holds its last value.
- FWD counter: O_Fwd_Cnt increments per issued word and saturates at all-ones.
- FWD exit: if the popped word has last=1, go to WAIT_DONE in the same edge. A 1-word program is legal.
- Ingress during FWD: may continue. Words after a last word stay queued until the next IDLE->FWD.
- WAIT_DONE:
  - Timeout counter starts at 0 on entry.
  - On I_Eng_Done, go to IDLE.
  - If the counter reaches TIMEOUT-1 without Done, set O_Timeout and go to IDLE.
  - If Done and expiry coincide, Done wins and O_Timeout is not set.
- O_Busy = (state != IDLE), registered.
- Egress FIFO is first-word-fall-through.
  - O_Host_Valid = !out_empty; O_Host_Data = head.
  - Pop when O_Host_Valid & I_Host_Ready.
- Egress push on I_Req_IF: if not full, push. If full and a pop occurs in the same cycle, push is accepted and the count is unchanged.
- Egress push when full with no pop: the word is dropped and O_Overflow is set.
- O_Overflow and O_Timeout clear only on reset.
- FIFO pointers wrap modulo depth. Count width is log2(depth)+1, so full = count==depth.
- Ingress and egress are independent; either may be active in any FSM state.

Test Plan:
- Reset: assert reset mid-clock -> all outputs 0 asynchronously; after release O_Host_Ready=1, O_Busy=0, O_Fwd_Cnt=0.
- 3-word program: push 0x11, 0x22, 0x33 (last on 0x33) back-to-back, I_Eng_Stall=0 -> O_Req_IF pulses carry 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after the first push. O_Fwd_Cnt=3, state WAIT_DONE. I_Eng_Done pulse -> O_Busy=0 next cycle.
- Stall and ingress full:
  - Hold I_Eng_Stall=1, push 8 words -> O_Host_Ready=0 after the 8th.
  - Release the stall -> 8 pulses in order, and O_Host_Ready returns 1 the cycle after the first pop.
- Timeout: TIMEOUT=16, 1-word program, no Done -> O_Timeout=1 exactly 16 cycles after entering WAIT_DONE, FSM back in IDLE.
- Done vs expiry: Done arrives in the same cycle as expiry -> O_Timeout stays 0.
- Egress overflow: I_Host_Ready=0, 9 I_Req_IF pulses with data 1..9 -> O_Overflow=1 and word 9 dropped. Drain yields 1..8 in order.
- Egress full, simultaneous push/pop: egress full, then I_Req_IF with 0xAA and I_Host_Ready=1 in the same cycle -> no overflow, count stays 8, 0xAA is the last word drained.
